// File: rtl/axi_wr_burst_sched.sv
// AXI4 write burst scheduler: splits a byte command into MAX_BURST / 4KB
// bursts and drains the write-data fifo onto AW/W/B once a burst is buffered.
module axi_wr_burst_sched #(
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 16,
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 7
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [LEN_W-1:0]    cmd_len,
    output logic                fifo_rd_en,
    input  logic [DATA_W-1:0]   fifo_dout,
    input  logic [CNT_W-1:0]    fifo_count,
    output logic                awvalid,
    input  logic                awready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                wvalid,
    input  logic                wready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    input  logic                bvalid,
    output logic                bready,
    input  logic [1:0]          bresp,
    output logic                done,
    output logic                err
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int BW    = LEN_W + 1;
    localparam int SW    = LEN_W + 2;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CALC = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_AW   = 3'd3;
    localparam logic [2:0] S_W    = 3'd4;
    localparam logic [2:0] S_B    = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]        state;
    logic [ADDR_W-1:0] cur_addr;
    logic [BW-1:0]     remaining;
    logic [BW-1:0]     blen;
    logic [BW-1:0]     beat_cnt;
    logic [OFF_W-1:0]  off;
    logic [OFF_W-1:0]  end_lane;
    logic              first_beat;
    logic              err_acc;

    logic [SW-1:0]     span;
    logic [BW-1:0]     beats_in;
    logic [OFF_W-1:0]  end_in;
    logic [12:0]       pg_beats;
    logic [BW-1:0]     cap;
    logic [BW-1:0]     blen_nx;
    logic              last_cmd_beat;
    logic [BYTES-1:0]  lo_mask;
    logic [BYTES-1:0]  hi_mask;

    // Command geometry and burst length for the current address
    always_comb begin
        span     = SW'(cmd_len) + SW'(cmd_addr[OFF_W-1:0]);
        beats_in = BW'((span + SW'(BYTES - 1)) >> OFF_W);
        end_in   = OFF_W'(span - SW'(1));
        pg_beats = 13'(4096 / BYTES) - 13'(cur_addr[11:OFF_W]);
        cap      = (remaining < BW'(MAX_BURST)) ? remaining : BW'(MAX_BURST);
        blen_nx  = (BW'(pg_beats) < cap) ? BW'(pg_beats) : cap;
    end

    // Scheduler FSM and burst bookkeeping
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            cur_addr   <= '0;
            remaining  <= '0;
            blen       <= '0;
            beat_cnt   <= '0;
            off        <= '0;
            end_lane   <= '0;
            first_beat <= 1'b0;
            err_acc    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cur_addr   <= cmd_addr;
                        off        <= cmd_addr[OFF_W-1:0];
                        remaining  <= beats_in;
                        end_lane   <= end_in;
                        first_beat <= 1'b1;
                        err_acc    <= 1'b0;
                        state      <= (cmd_len == '0) ? S_DONE : S_CALC;
                    end
                end
                S_CALC: begin
                    blen     <= blen_nx;
                    beat_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (BW'(fifo_count) >= blen)
                        state <= S_AW;
                end
                S_AW: begin
                    if (awready)
                        state <= S_W;
                end
                S_W: begin
                    if (wready) begin
                        first_beat <= 1'b0;
                        beat_cnt   <= beat_cnt + BW'(1);
                        if (wlast)
                            state <= S_B;
                    end
                end
                S_B: begin
                    if (bvalid) begin
                        err_acc   <= err_acc | (bresp != 2'b00);
                        cur_addr  <= {cur_addr[ADDR_W-1:OFF_W]
                                      + (ADDR_W-OFF_W)'(blen),
                                      {OFF_W{1'b0}}};
                        remaining <= remaining - blen;
                        state     <= (remaining == blen) ? S_DONE : S_CALC;
                    end
                end
                S_DONE: begin
                    err_acc <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // AXI channel outputs decoded from state
    always_comb begin
        cmd_ready     = (state == S_IDLE);
        awvalid       = (state == S_AW);
        awaddr        = cur_addr;
        awlen         = 8'(blen - BW'(1));
        awsize        = 3'(OFF_W);
        awburst       = 2'b01;
        wvalid        = (state == S_W);
        wdata         = fifo_dout;
        wlast         = wvalid && (beat_cnt == blen - BW'(1));
        last_cmd_beat = wlast && (remaining == blen);
        lo_mask       = {BYTES{1'b1}} << off;
        hi_mask       = {BYTES{1'b1}} >> (OFF_W'(BYTES - 1) - end_lane);
        wstrb         = {BYTES{1'b1}};
        if (first_beat)
            wstrb = wstrb & lo_mask;
        if (last_cmd_beat)
            wstrb = wstrb & hi_mask;
        fifo_rd_en    = wvalid && wready;
        bready        = (state == S_B);
        done          = (state == S_DONE);
        err           = done && err_acc;
    end

endmodule

// File: tb/tb_axi_wr_burst_sched.sv
// Directed bench for axi_wr_burst_sched with a fifo model and AXI slave
// responder; expected bursts and strobes are hand-computed per vector.
module tb_axi_wr_burst_sched;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [31:0]  cmd_addr = '0;
    logic [15:0]  cmd_len = '0;
    logic         fifo_rd_en;
    logic [127:0] fifo_dout;
    logic [6:0]   fifo_count;
    logic         awvalid;
    logic         awready = 1'b0;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         wvalid;
    logic         wready = 1'b0;
    logic [127:0] wdata;
    logic [15:0]  wstrb;
    logic         wlast;
    logic         bvalid = 1'b0;
    logic         bready;
    logic [1:0]   bresp = 2'b00;
    logic         done;
    logic         err;

    axi_wr_burst_sched dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
        .fifo_count(fifo_count),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] word(input int k);
        return {4{32'hD000_0000 + 32'(k)}};
    endfunction

    // fifo model: words are a function of their absolute index
    int rd_ptr = 0;
    int wr_ptr = 0;
    assign fifo_count = 7'(wr_ptr - rd_ptr);
    assign fifo_dout  = word(rd_ptr);
    always @(posedge clk)
        if (fifo_rd_en) rd_ptr <= rd_ptr + 1;

    // slave responder knobs
    bit w_rnd = 0;
    bit w_hold = 0;
    bit a_rnd = 0;
    int err_burst = -1;
    int b_in_cmd = 0;

    initial forever begin
        @(posedge clk);
        #1;
        awready = a_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        wready  = w_hold ? 1'b0 :
                  (w_rnd ? 1'($urandom_range(0, 1)) : 1'b1);
        bvalid  = bready;
        bresp   = (b_in_cmd == err_burst) ? 2'b10 : 2'b00;
    end

    // monitor
    logic [31:0]  aw_addr_q[$];
    int           aw_len_q[$];
    logic [15:0]  w_strb_q[$];
    bit           w_last_q[$];
    int           exp_idx = 0;
    int           done_cnt = 0;
    bit           last_err = 0;
    bit           w_stall = 0;
    bit           a_stall = 0;
    logic [127:0] pw_data;
    logic [15:0]  pw_strb;
    logic         pw_last;
    logic [31:0]  pa_addr;
    logic [7:0]   pa_len;

    initial forever begin
        @(negedge clk);
        if (resetn) begin
            chk("pop", 128'(fifo_rd_en), 128'(wvalid && wready));
            if (awvalid)
                chk("aw_gate", 128'(int'(fifo_count) >= int'(awlen) + 1),
                    128'(1));
            if (w_stall && wvalid) begin
                chk("w_stable_data", wdata, pw_data);
                chk("w_stable_strb", 128'(wstrb), 128'(pw_strb));
                chk("w_stable_last", 128'(wlast), 128'(pw_last));
            end
            if (a_stall && awvalid) begin
                chk("aw_stable_addr", 128'(awaddr), 128'(pa_addr));
                chk("aw_stable_len", 128'(awlen), 128'(pa_len));
            end
            w_stall = wvalid && !wready;
            a_stall = awvalid && !awready;
            pw_data = wdata;
            pw_strb = wstrb;
            pw_last = wlast;
            pa_addr = awaddr;
            pa_len  = awlen;
            if (awvalid && awready) begin
                aw_addr_q.push_back(awaddr);
                aw_len_q.push_back(int'(awlen));
            end
            if (wvalid && wready) begin
                chk("wdata", wdata, word(exp_idx));
                exp_idx++;
                w_strb_q.push_back(wstrb);
                w_last_q.push_back(wlast);
            end
            if (bvalid && bready) b_in_cmd++;
            if (done) begin
                done_cnt++;
                last_err = err;
            end
        end else begin
            w_stall = 0;
            a_stall = 0;
        end
    end

    task automatic start_cmd(input logic [31:0] a, input logic [15:0] l,
                             input int fill);
        aw_addr_q.delete();
        aw_len_q.delete();
        w_strb_q.delete();
        w_last_q.delete();
        b_in_cmd = 0;
        done_cnt = 0;
        wr_ptr   = rd_ptr + fill;
        exp_idx  = rd_ptr;
        @(negedge clk);
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int cycles);
        cycles = 0;
        while (done_cnt == 0 && cycles < 3000) begin
            @(posedge clk);
            cycles++;
        end
        chk({tag, "_done"}, 128'(done_cnt), 128'(1));
    endtask

    task automatic chk_burst(input string tag, input int i,
                             input logic [31:0] a, input int l);
        if (i < aw_addr_q.size()) begin
            chk({tag, "_awaddr"}, 128'(aw_addr_q[i]), 128'(a));
            chk({tag, "_awlen"}, 128'(aw_len_q[i]), 128'(l));
        end else begin
            chk({tag, "_aw_missing"}, 128'(aw_addr_q.size()), 128'(i + 1));
        end
    endtask

    task automatic chk_beats(input string tag, input int n,
                             input logic [15:0] s_first,
                             input logic [15:0] s_last, input int blen);
        chk({tag, "_beats"}, 128'(w_strb_q.size()), 128'(n));
        for (int i = 0; i < w_strb_q.size() && i < n; i++) begin
            logic [15:0] es;
            es = 16'hFFFF;
            if (i == 0) es = es & s_first;
            if (i == n - 1) es = es & s_last;
            chk({tag, "_wstrb"}, 128'(w_strb_q[i]), 128'(es));
            chk({tag, "_wlast"}, 128'(w_last_q[i]),
                128'((i % blen) == blen - 1 || i == n - 1));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int p0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 128'(cmd_ready), 128'(1));
        chk("rst_awvalid", 128'(awvalid), 128'(0));
        chk("rst_wvalid", 128'(wvalid), 128'(0));
        chk("rst_wlast", 128'(wlast), 128'(0));
        chk("rst_bready", 128'(bready), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_pop", 128'(fifo_rd_en), 128'(0));
        chk("awsize", 128'(awsize), 128'(4));
        chk("awburst", 128'(awburst), 128'(1));
        resetn = 1'b1;

        // 1: aligned 64 bytes
        start_cmd(32'h1000, 16'd64, 4);
        wait_done("t1", cyc);
        chk("t1_err", 128'(last_err), 128'(0));
        chk("t1_nbursts", 128'(aw_addr_q.size()), 128'(1));
        chk_burst("t1", 0, 32'h1000, 3);
        chk_beats("t1", 4, 16'hFFFF, 16'hFFFF, 4);

        // 2: misaligned start and end, random W/AW gaps
        w_rnd = 1;
        a_rnd = 1;
        start_cmd(32'h1003, 16'd20, 2);
        wait_done("t2", cyc);
        chk_burst("t2", 0, 32'h1003, 1);
        chk_beats("t2", 2, 16'hFFF8, 16'h007F, 2);
        w_rnd = 0;
        a_rnd = 0;

        // 3: 4KB split
        start_cmd(32'h0FC0, 16'd256, 16);
        wait_done("t3", cyc);
        chk("t3_nbursts", 128'(aw_addr_q.size()), 128'(2));
        chk_burst("t3", 0, 32'h0FC0, 3);
        chk_burst("t3", 1, 32'h1000, 11);
        chk("t3_last4", 128'(w_last_q.size() > 3 ? w_last_q[3] : 1'b0),
            128'(1));

        // 4: MAX_BURST split
        p0 = rd_ptr;
        start_cmd(32'h0, 16'd512, 32);
        wait_done("t4", cyc);
        chk_burst("t4", 0, 32'h0, 15);
        chk_burst("t4", 1, 32'h100, 15);
        chk_beats("t4", 32, 16'hFFFF, 16'hFFFF, 16);
        chk("t4_pops", 128'(rd_ptr - p0), 128'(32));

        // 5: insufficient fifo data holds AW
        w_rnd = 1;
        start_cmd(32'h2000, 16'd64, 2);
        repeat (10) @(negedge clk);
        chk("t5_aw_held", 128'(awvalid), 128'(0));
        chk("t5_no_aw", 128'(aw_addr_q.size()), 128'(0));
        wr_ptr = wr_ptr + 2;
        wait_done("t5", cyc);
        chk_burst("t5", 0, 32'h2000, 3);
        chk_beats("t5", 4, 16'hFFFF, 16'hFFFF, 4);
        w_rnd = 0;

        // 6: error response on first burst, then clean command
        err_burst = 0;
        start_cmd(32'h3000, 16'd512, 32);
        wait_done("t6a", cyc);
        chk("t6a_err", 128'(last_err), 128'(1));
        chk("t6a_nbursts", 128'(aw_addr_q.size()), 128'(2));
        err_burst = -1;
        start_cmd(32'h4000, 16'd64, 4);
        wait_done("t6b", cyc);
        chk("t6b_err", 128'(last_err), 128'(0));

        // reset in the middle of W
        w_hold = 1;
        start_cmd(32'h5000, 16'd256, 16);
        cyc = 0;
        while (!wvalid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_mid_reached_w", 128'(wvalid), 128'(1));
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_wvalid", 128'(wvalid), 128'(0));
        chk("rst_mid_cmd_ready", 128'(cmd_ready), 128'(1));
        chk("rst_mid_awvalid", 128'(awvalid), 128'(0));
        @(negedge clk);
        resetn = 1'b1;
        w_hold = 0;
        repeat (4) @(negedge clk);
        chk("rst_mid_no_done", 128'(done_cnt), 128'(0));

        // zero length
        start_cmd(32'h6000, 16'd0, 0);
        wait_done("t_len0", cyc);
        chk("t_len0_latency", 128'(cyc <= 3), 128'(1));
        chk("t_len0_no_aw", 128'(aw_addr_q.size()), 128'(0));
        chk("t_len0_err", 128'(last_err), 128'(0));

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
